unified_mem_arbiter: RTL and testbench

- Shares one single-ported synchronous RAM between the instruction-fetch port and the data-memory port of the 5-stage pipeline.
- Arbitrates between the two ports and sequences the RAM access for a fixed latency.
- Returns registered read data with a one-cycle ack pulse.
- Drives per-stage stall outputs that the pipeline ORs into its PC_write/IF_ID_write and downstream hold logic.
- Data port has priority, with a fairness counter so fetch is never starved.

---
 rtl/unified_mem_arbiter_pkg.sv | 24 ++
 rtl/unified_mem_arbiter_if.sv | 34 +++
 rtl/unified_mem_arbiter_mem_grant_select.sv | 42 ++++
 rtl/unified_mem_arbiter.sv | 111 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and width helpers for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_MEM = 1'b1
    } port_id_t;

    function automatic int lat_width(input int ram_latency);
        return $clog2(ram_latency + 1);
    endfunction

    function automatic int run_width(input int max_mem_run);
        return $clog2(max_mem_run + 1);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch port, data port and RAM-side signals of the arbiter; master = pipeline/RAM side, slave = arbiter.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              stall_if;
    logic              stall_mem;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack, ram_en, ram_we, ram_addr, ram_wdata,
               stall_if, stall_mem
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ack, mem_rdata, mem_ack, ram_en, ram_we, ram_addr, ram_wdata,
               stall_if, stall_mem
    );
endinterface

// File: rtl/unified_mem_arbiter_mem_grant_select.sv
// Data-port-priority winner pick with a run counter that forces a fetch grant after MAX_MEM_RUN data grants.
module mem_grant_select
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MAX_MEM_RUN = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_if_req,
    input  logic     i_mem_req,
    input  logic     i_grant,
    output port_id_t o_winner
);
    localparam int RUN_W = run_width(MAX_MEM_RUN);

    logic [RUN_W-1:0] r_mem_run;
    logic             w_run_full;

    assign w_run_full = (r_mem_run == RUN_W'(MAX_MEM_RUN));

    always_comb begin
        o_winner = PORT_IF;
        if (i_mem_req && !(i_if_req && w_run_full)) begin
            o_winner = PORT_MEM;
        end
    end

    // Run only grows while a fetch is actually waiting behind the data port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_run <= '0;
        end else if (i_grant) begin
            if (o_winner == PORT_MEM && i_if_req) begin
                if (!w_run_full) begin
                    r_mem_run <= r_mem_run + 1'b1;
                end
            end else begin
                r_mem_run <= '0;
            end
        end
    end
endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported synchronous RAM between fetch and data ports, one access at a time.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_MEM_RUN = 4
) (
    input logic                  clk,
    input logic                  reset,
    unified_mem_arbiter_if.slave bus
);
    localparam int LAT_W = lat_width(RAM_LATENCY);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    port_id_t          r_port;
    port_id_t          w_winner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [LAT_W-1:0]  r_lat;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_mem_rdata;
    logic              w_grant;
    logic              w_capture;
    logic              w_unused;

    assign w_grant   = (r_state == IDLE) && (bus.if_req || bus.mem_req);
    assign w_capture = (r_state == WAIT) && (r_lat == '0);
    assign w_unused  = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                         bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

    mem_grant_select #(
        .MAX_MEM_RUN(MAX_MEM_RUN)
    ) u_grant (
        .clk      (clk),
        .reset    (reset),
        .i_if_req (bus.if_req),
        .i_mem_req(bus.mem_req),
        .i_grant  (w_grant),
        .o_winner (w_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_next_state = ISSUE;
            ISSUE:   w_next_state = r_we ? DONE : WAIT;
            WAIT:    if (r_lat == '0) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_port      <= PORT_IF;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_lat       <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_port <= w_winner;
                if (w_winner == PORT_MEM) begin
                    r_addr  <= bus.mem_addr[ADDR_W+1:2];
                    r_we    <= bus.mem_we;
                    r_wdata <= bus.mem_wdata;
                end else begin
                    r_addr  <= bus.if_addr[ADDR_W+1:2];
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                end
            end
            if (r_state == ISSUE && !r_we) begin
                r_lat <= LAT_W'(RAM_LATENCY - 1);
            end else if (r_state == WAIT && r_lat != '0) begin
                r_lat <= r_lat - 1'b1;
            end
            if (w_capture) begin
                if (r_port == PORT_MEM) begin
                    r_mem_rdata <= bus.ram_rdata;
                end else begin
                    r_if_rdata <= bus.ram_rdata;
                end
            end
        end
    end

    assign bus.ram_en    = (r_state == ISSUE);
    assign bus.ram_we    = (r_state == ISSUE) && r_we;
    assign bus.ram_addr  = r_addr;
    assign bus.ram_wdata = r_wdata;
    assign bus.if_ack    = (r_state == DONE) && (r_port == PORT_IF);
    assign bus.mem_ack   = (r_state == DONE) && (r_port == PORT_MEM);
    assign bus.if_rdata  = r_if_rdata;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.stall_if  = bus.if_req && !bus.if_ack;
    assign bus.stall_mem = bus.mem_req && !bus.mem_ack;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: RAM_LATENCY=1 and RAM_LATENCY=3 instances against a word-level memory model.
module tb_unified_mem_arbiter;
    localparam int MAXRUN = 4;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst3 = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] exp_mem_rd = '0;

    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(10)) b1 ();
    unified_mem_arbiter_if #(.ADDR_W(10)) b3 ();

    unified_mem_arbiter #(.ADDR_W(10), .RAM_LATENCY(1), .MAX_MEM_RUN(MAXRUN)) dut (
        .clk(clk), .reset(rst1), .bus(b1.slave));
    unified_mem_arbiter #(.ADDR_W(10), .RAM_LATENCY(3), .MAX_MEM_RUN(MAXRUN)) dut3 (
        .clk(clk), .reset(rst3), .bus(b3.slave));

    function automatic logic [31:0] init_word(input int w);
        return (w == 4) ? 32'hDEADBEEF : (32'h5A000077 ^ (32'(w) * 32'h00010003));
    endfunction

    // RAM behind the latency-1 instance: data is valid only the cycle after a read strobe.
    bit [31:0] ram1 [1024];
    bit        ram1_v [1024];
    always @(posedge clk) begin
        if (b1.ram_en && b1.ram_we) begin
            ram1[b1.ram_addr]   <= b1.ram_wdata;
            ram1_v[b1.ram_addr] <= 1'b1;
        end
        if (b1.ram_en && !b1.ram_we)
            b1.ram_rdata <= ram1_v[b1.ram_addr] ? ram1[b1.ram_addr] : init_word(int'(b1.ram_addr));
        else
            b1.ram_rdata <= $urandom;
    end

    // Latency-3 RAM: data appears exactly three cycles after the strobe, junk otherwise.
    bit [31:0] d3 [3];
    bit        v3 [3];
    logic [31:0] junk3;
    always @(posedge clk) begin
        junk3 <= $urandom;
        d3[0] <= init_word(int'(b3.ram_addr));
        v3[0] <= b3.ram_en && !b3.ram_we;
        d3[1] <= d3[0]; v3[1] <= v3[0];
        d3[2] <= d3[1]; v3[2] <= v3[1];
    end
    assign b3.ram_rdata = v3[2] ? d3[2] : junk3;

    bit [31:0] ref_val [1024];
    bit        ref_w [1024];
    function automatic logic [31:0] ref_read(input int w);
        return ref_w[w] ? ref_val[w] : init_word(w);
    endfunction

    function automatic logic [111:0] outs1();
        return {b1.if_rdata, b1.if_ack, b1.mem_rdata, b1.mem_ack, b1.ram_en, b1.ram_we,
                b1.ram_addr, b1.ram_wdata, b1.stall_if, b1.stall_mem};
    endfunction
    function automatic logic [111:0] outs3();
        return {b3.if_rdata, b3.if_ack, b3.mem_rdata, b3.mem_ack, b3.ram_en, b3.ram_we,
                b3.ram_addr, b3.ram_wdata, b3.stall_if, b3.stall_mem};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vectors++;
        if (outs1() !== 112'd0) begin
            miscompares++; $display("FAIL reset_outs_lat1 got %h exp 0", outs1());
        end
        vectors++;
        if (outs3() !== 112'd0) begin
            miscompares++; $display("FAIL reset_outs_lat3 got %h exp 0", outs3());
        end
        rst1 = 1'b0; rst3 = 1'b0;
        tick();
    endtask

    task automatic test_if_read();
        b1.if_addr = 32'h10; b1.if_req = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            #1;
            vectors++;
            if ({b1.ram_en, b1.if_ack, b1.stall_if} !== {1'(k == 1), 1'(k == 3), 1'(k < 3)}) begin
                miscompares++;
                $display("FAIL if_read_timing k=%0d got en/ack/stall %b%b%b exp %b%b%b", k,
                         b1.ram_en, b1.if_ack, b1.stall_if, k == 1, k == 3, k < 3);
            end
            if (k == 1) begin
                vectors++;
                if ({b1.ram_addr, b1.ram_we} !== {10'd4, 1'b0}) begin
                    miscompares++; $display("FAIL if_read_ram_addr got %0d we %b exp 4 we 0", b1.ram_addr, b1.ram_we);
                end
            end
            if (k >= 3) begin
                vectors++;
                if (b1.if_rdata !== 32'hDEADBEEF) begin
                    miscompares++; $display("FAIL if_read_data k=%0d got %h exp deadbeef", k, b1.if_rdata);
                end
                b1.if_req = 1'b0;
            end
            if (k < 4) tick();
        end
    endtask

    task automatic test_mem_write_read();
        b1.mem_addr = 32'h20; b1.mem_we = 1'b1; b1.mem_wdata = 32'h12345678; b1.mem_req = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            #1;
            vectors++;
            if ({b1.ram_en, b1.ram_we, b1.mem_ack} !== {1'(k == 1), 1'(k == 1), 1'(k == 2)}) begin
                miscompares++;
                $display("FAIL mem_write_timing k=%0d got en/we/ack %b%b%b", k, b1.ram_en, b1.ram_we, b1.mem_ack);
            end
            if (k == 1) begin
                vectors++;
                if ({b1.ram_addr, b1.ram_wdata} !== {10'd8, 32'h12345678}) begin
                    miscompares++; $display("FAIL mem_write_ram got addr %0d data %h exp 8 12345678", b1.ram_addr, b1.ram_wdata);
                end
            end
            if (k == 2) begin
                vectors++;
                if (b1.mem_rdata !== exp_mem_rd) begin
                    miscompares++; $display("FAIL mem_write_rdata_held got %h exp %h", b1.mem_rdata, exp_mem_rd);
                end
                b1.mem_req = 1'b0;
                ref_val[8] = 32'h12345678; ref_w[8] = 1'b1;
            end
            tick();
        end
        b1.mem_we = 1'b0; b1.mem_req = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            #1;
            vectors++;
            if ({b1.ram_en, b1.ram_we, b1.mem_ack} !== {1'(k == 1), 1'b0, 1'(k == 3)}) begin
                miscompares++;
                $display("FAIL mem_read_timing k=%0d got en/we/ack %b%b%b", k, b1.ram_en, b1.ram_we, b1.mem_ack);
            end
            if (k == 3) begin
                vectors++;
                if (b1.mem_rdata !== ref_read(8)) begin
                    miscompares++; $display("FAIL mem_read_data got %h exp %h", b1.mem_rdata, ref_read(8));
                end
                exp_mem_rd = ref_read(8);
                b1.mem_req = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        int k_mem = -1;
        int k_if = -1;
        rst1 = 1'b1; tick(); rst1 = 1'b0; exp_mem_rd = '0;
        b1.mem_addr = 32'h40; b1.mem_we = 1'b0; b1.mem_req = 1'b1;
        b1.if_addr = 32'h44; b1.if_req = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            #1;
            if (b1.mem_ack && k_mem < 0) begin
                k_mem = k; b1.mem_req = 1'b0;
                vectors++;
                if (b1.mem_rdata !== ref_read(16)) begin
                    miscompares++; $display("FAIL simul_mem_data got %h exp %h", b1.mem_rdata, ref_read(16));
                end
                exp_mem_rd = ref_read(16);
            end
            if (b1.if_ack && k_if < 0) begin
                k_if = k; b1.if_req = 1'b0;
                vectors++;
                if (b1.if_rdata !== ref_read(17)) begin
                    miscompares++; $display("FAIL simul_if_data got %h exp %h", b1.if_rdata, ref_read(17));
                end
            end
            tick();
        end
        b1.mem_req = 1'b0; b1.if_req = 1'b0;
        vectors++;
        if (k_mem != 3 || k_if != 7) begin
            miscompares++; $display("FAIL simul_ack_cycles got mem %0d if %0d exp mem 3 if 7", k_mem, k_if);
        end
    endtask

    task automatic test_fairness();
        int run = 0;
        int n = 0;
        int cyc = 0;
        int exp_port;
        int got;
        logic last_we = 1'b0;
        rst1 = 1'b1; tick(); rst1 = 1'b0; exp_mem_rd = '0;
        b1.if_addr = 32'h80; b1.if_req = 1'b1;
        b1.mem_addr = 32'h3F0; b1.mem_we = 1'b1; b1.mem_wdata = 32'hCAFE0000; b1.mem_req = 1'b1;
        while (n < 10 && cyc < 80) begin
            tick(); cyc++;
            if (b1.ram_en) last_we = b1.ram_we;
            if (b1.if_ack || b1.mem_ack) begin
                exp_port = (run == MAXRUN) ? 0 : 1;
                run = (exp_port == 1) ? run + 1 : 0;
                got = b1.mem_ack ? 1 : 0;
                vectors++;
                if (got != exp_port) begin
                    miscompares++; $display("FAIL fair_grant_%0d got port %0d exp %0d", n, got, exp_port);
                end
                if (got == 0) begin
                    vectors++;
                    if (last_we !== 1'b0 || b1.if_rdata !== ref_read(32)) begin
                        miscompares++; $display("FAIL fair_if_access_%0d got we %b data %h exp we 0 data %h",
                                                n, last_we, b1.if_rdata, ref_read(32));
                    end
                end else begin
                    ref_val[252] = 32'hCAFE0000; ref_w[252] = 1'b1;
                end
                n++;
            end
        end
        b1.if_req = 1'b0; b1.mem_req = 1'b0;
        vectors++;
        if (n != 10) begin
            miscompares++; $display("FAIL fair_timeout got %0d acks exp 10", n);
        end
        tick(); tick();
    endtask

    task automatic test_latency3();
        int w = $urandom_range(0, 1023);
        int ens = 0;
        b3.if_addr = ($urandom & 32'hFFFFF000) | 32'(w << 2) | ($urandom & 32'h3);
        b3.if_req = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            #1;
            if (b3.ram_en) ens++;
            vectors++;
            if ({b3.ram_en, b3.if_ack} !== {1'(k == 1), 1'(k == 5)}) begin
                miscompares++; $display("FAIL lat3_timing k=%0d got en/ack %b%b", k, b3.ram_en, b3.if_ack);
            end
            if (k == 1) begin
                vectors++;
                if (b3.ram_addr !== 10'(w)) begin
                    miscompares++; $display("FAIL lat3_ram_addr got %0d exp %0d", b3.ram_addr, w);
                end
            end
            if (k == 5) begin
                vectors++;
                if (b3.if_rdata !== init_word(w)) begin
                    miscompares++; $display("FAIL lat3_data got %h exp %h", b3.if_rdata, init_word(w));
                end
                b3.if_req = 1'b0;
            end
            tick();
        end
        vectors++;
        if (ens != 1) begin
            miscompares++; $display("FAIL lat3_single_strobe got %0d exp 1", ens);
        end
    endtask

    task automatic test_reset_in_wait();
        int acks = 0;
        b3.mem_addr = 32'h14; b3.mem_we = 1'b0; b3.mem_req = 1'b1;
        tick(); tick();
        rst3 = 1'b1; b3.mem_req = 1'b0;
        tick();
        rst3 = 1'b0;
        vectors++;
        if (outs3() !== 112'd0) begin
            miscompares++; $display("FAIL rst_wait_outs got %h exp 0", outs3());
        end
        for (int k = 0; k < 6; k++) begin
            if (b3.mem_ack || b3.if_ack) acks++;
            tick();
        end
        vectors++;
        if (acks != 0) begin
            miscompares++; $display("FAIL rst_wait_no_ack got %0d acks exp 0", acks);
        end
        b3.mem_req = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            #1;
            vectors++;
            if (b3.mem_ack !== 1'(k == 5)) begin
                miscompares++; $display("FAIL rst_wait_reissue_ack k=%0d got %b exp %b", k, b3.mem_ack, k == 5);
            end
            if (k == 5) begin
                vectors++;
                if (b3.mem_rdata !== init_word(5)) begin
                    miscompares++; $display("FAIL rst_wait_reissue_data got %h exp %h", b3.mem_rdata, init_word(5));
                end
                b3.mem_req = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_random();
        int run = 0;
        int q[$];
        int ifw;
        int memw;
        int mode;
        bit pi;
        bit pm;
        int got;
        int e;
        rst1 = 1'b1; tick(); rst1 = 1'b0; exp_mem_rd = '0;
        for (int it = 0; it < 40; it++) begin
            tick();
            mode = $urandom_range(1, 3);
            pi = mode[0]; pm = mode[1];
            ifw = $urandom_range(0, 15); memw = $urandom_range(0, 15);
            if (pi) begin
                b1.if_addr = ($urandom & 32'hFFFFF000) | 32'(ifw << 2) | ($urandom & 32'h3);
                b1.if_req = 1'b1;
            end
            if (pm) begin
                b1.mem_addr = ($urandom & 32'hFFFFF000) | 32'(memw << 2) | ($urandom & 32'h3);
                b1.mem_we = 1'($urandom); b1.mem_wdata = $urandom; b1.mem_req = 1'b1;
            end
            // Both pending: data port wins until it has run MAXRUN times past a waiting fetch.
            while (pi || pm) begin
                if (pm && !(pi && run == MAXRUN)) begin
                    q.push_back(1); run = pi ? ((run < MAXRUN) ? run + 1 : MAXRUN) : 0; pm = 0;
                end else begin
                    q.push_back(0); run = 0; pi = 0;
                end
            end
            for (int c = 0; c < 20 && q.size() > 0; c++) begin
                tick();
                if (b1.if_ack || b1.mem_ack) begin
                    got = b1.mem_ack ? 1 : 0;
                    e = q.pop_front();
                    vectors++;
                    if (got != e) begin
                        miscompares++; $display("FAIL rand_order it=%0d got port %0d exp %0d", it, got, e);
                    end
                    if (got == 0) begin
                        vectors++;
                        if (b1.if_rdata !== ref_read(ifw)) begin
                            miscompares++; $display("FAIL rand_if_data it=%0d got %h exp %h", it, b1.if_rdata, ref_read(ifw));
                        end
                        b1.if_req = 1'b0;
                    end else begin
                        if (b1.mem_we) begin
                            ref_val[memw] = b1.mem_wdata; ref_w[memw] = 1'b1;
                        end else begin
                            exp_mem_rd = ref_read(memw);
                        end
                        vectors++;
                        if (b1.mem_rdata !== exp_mem_rd) begin
                            miscompares++; $display("FAIL rand_mem_data it=%0d got %h exp %h", it, b1.mem_rdata, exp_mem_rd);
                        end
                        b1.mem_req = 1'b0;
                    end
                end
            end
            vectors++;
            if (q.size() != 0) begin
                miscompares++; $display("FAIL rand_timeout it=%0d pending %0d", it, q.size());
                q.delete();
            end
            b1.if_req = 1'b0; b1.mem_req = 1'b0;
        end
    endtask

    initial begin
        b1.if_req = 1'b0; b1.if_addr = '0; b1.mem_req = 1'b0; b1.mem_we = 1'b0;
        b1.mem_addr = '0; b1.mem_wdata = '0;
        b3.if_req = 1'b0; b3.if_addr = '0; b3.mem_req = 1'b0; b3.mem_we = 1'b0;
        b3.mem_addr = '0; b3.mem_wdata = '0;
        tick(); tick();
        test_reset();
        test_if_read();
        test_mem_write_read();
        test_simultaneous();
        test_fairness();
        test_latency3();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
